// File: rtl/rnd_vec_pkg.sv
// rnd_vec_pkg: shared types and helpers for the lagged-Fibonacci vector generator
// Contents: seeding FSM state enum, xorshift32 step, clog2 and slot-index width helpers.
package rnd_vec_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WARM} state_t;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        return y ^ (y << 5);
    endfunction

    function automatic int rnd_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int rnd_slot_w(input int slots);
        return (rnd_clog2(slots) < 1) ? 1 : rnd_clog2(slots);
    endfunction

endpackage

// File: rtl/rnd_xorshift32.sv
// rnd_xorshift32: 32-bit xorshift seed expander
// Ports: clk, rst_n (async, active-low), load (x <= seed, 0 mapped to 1),
//        adv (x <= next), seed [31:0], x_nxt [31:0] (value x advances to).
module rnd_xorshift32
    import rnd_vec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] x_nxt
);

    logic [31:0] x;

    assign x_nxt = xorshift32(x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    x <= 32'h1;
        else if (load) x <= (seed == 32'h0) ? 32'h1 : seed;
        else if (adv)  x <= x_nxt;
    end

endmodule

// File: rtl/rnd_vec_gen_mslot.sv
// rnd_vec_gen_mslot: lagged-Fibonacci vector generator with seeding FSM and multi-slot checkpoints
// Ports: clk, rst_n (async, active-low); seed_start/seed start deterministic seeding;
//        save/restore/next one-cycle command strobes; slot selects the checkpoint;
//        out = state word 0; busy = seeding in progress; restore_err = one-cycle pulse
//        after a restore from a never-saved or out-of-range slot.
// Build option: RNDGEN_SIMPLE_EN replaces the lag state with a single counter word.
module rnd_vec_gen_mslot
    import rnd_vec_pkg::*;
#(
    parameter  int OUT_SIZE      = 16,
    parameter  int LFSR_LENGTH   = 55,
    parameter  int LFSR_FEEDBACK = 24,
    parameter  int SLOTS         = 4,
    parameter  int WARMUP        = 64,
    localparam int SLOT_W        = rnd_slot_w(SLOTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seed_start,
    input  logic [31:0]         seed,
    input  logic                save,
    input  logic                restore,
    input  logic                next,
    input  logic [SLOT_W-1:0]   slot,
    output logic [OUT_SIZE-1:0] out,
    output logic                busy,
    output logic                restore_err
);

    localparam int              NS      = 1 << SLOT_W;
    localparam int              CNT_W   = rnd_clog2(LFSR_LENGTH + WARMUP + 1);
    localparam logic [SLOT_W:0] SLOTS_L = (SLOT_W + 1)'(SLOTS);
`ifdef RNDGEN_SIMPLE_EN
    localparam bit              SIMPLE  = 1'b1;
`else
    localparam bit              SIMPLE  = 1'b0;
`endif

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt;
    logic [NS-1:0]    v;
    logic             fill_done, warm_done, idle, cmd, slot_ok, sel_valid;
    logic             do_restore, bad_restore, do_save, do_next;

    assign fill_done   = SIMPLE || cnt == CNT_W'(LFSR_LENGTH - 1);
    assign warm_done   = cnt == CNT_W'(WARMUP - 1);
    assign idle        = st == IDLE;
    assign busy        = !idle;
    // seed_start outranks every other command; the FSM leaves IDLE on that edge
    assign cmd         = idle && !seed_start;
    assign slot_ok     = {1'b0, slot} < SLOTS_L;
    // valid bits above SLOTS are never set, so out-of-range restores fail here too
    assign sel_valid   = v[slot];
    assign do_restore  = cmd && restore && sel_valid;
    assign bad_restore = cmd && restore && !sel_valid;
    assign do_save     = cmd && !restore && save && slot_ok;
    assign do_next     = cmd && !restore && !save && next;

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = seed_start ? FILL : IDLE;
            FILL:    st_n = !fill_done ? FILL : (SIMPLE || WARMUP == 0) ? IDLE : WARM;
            WARM:    st_n = warm_done ? IDLE : WARM;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            cnt         <= '0;
            v           <= '0;
            restore_err <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= (st_n != st) ? '0 : cnt + 1'b1;
            restore_err <= bad_restore;
            if (do_save) v[slot] <= 1'b1;
        end
    end

`ifdef RNDGEN_SIMPLE_EN
    logic [OUT_SIZE-1:0] front;
    logic [OUT_SIZE-1:0] seed_w;
    logic [OUT_SIZE-1:0] s [NS];

    assign seed_w = OUT_SIZE'(seed);
    assign out    = front;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    front <= OUT_SIZE'(1);
        else if (idle && seed_start)   front <= (seed_w != '0) ? seed_w : OUT_SIZE'(2);
        else if (do_restore)           front <= s[slot];
        else if (do_next)              front <= (front != '0) ? front + 1'b1 : OUT_SIZE'(2);
    end

    always_ff @(posedge clk) begin
        if (do_save) s[slot] <= front;
    end
`else
    localparam int REP = (OUT_SIZE + 31) / 32;

    logic [OUT_SIZE-1:0] w [LFSR_LENGTH];
    logic [OUT_SIZE-1:0] s [NS][LFSR_LENGTH];
    logic [31:0]         x_nxt;
    logic [32*REP-1:0]   fill_wide;
    logic [OUT_SIZE-1:0] step_w;
    logic                any_lsb;

    rnd_xorshift32 u_xs (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (idle && seed_start),
        .adv   (st == FILL),
        .seed  (seed),
        .x_nxt (x_nxt)
    );

    assign fill_wide = {REP{x_nxt}};

    always_comb begin
        any_lsb = 1'b0;
        for (int i = 0; i < LFSR_LENGTH; i++) any_lsb |= w[i][0];
    end

    // forcing the LSB when every word is even keeps the stream from collapsing to even values
    assign step_w = (w[LFSR_LENGTH-1] + w[LFSR_FEEDBACK-1]) | OUT_SIZE'(!any_lsb);
    assign out    = w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LFSR_LENGTH; i++) w[i] <= OUT_SIZE'(i == 0);
        end else if (busy || do_next) begin
            w[0] <= (st == FILL) ? fill_wide[OUT_SIZE-1:0] : step_w;
            for (int i = 1; i < LFSR_LENGTH; i++) w[i] <= w[i-1];
        end else if (do_restore) begin
            w <= s[slot];
        end
    end

    always_ff @(posedge clk) begin
        if (do_save) s[slot] <= w;
    end
`endif

endmodule

// File: tb/tb_rnd_vec_gen_mslot.sv
// tb_rnd_vec_gen_mslot: randomized self-checking bench against a queue-based reference model
module tb_rnd_vec_gen_mslot;

    localparam int W = 8, L = 7, F = 3, NSL = 4, WU = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_start = 1'b0, save = 1'b0, restore = 1'b0, next = 1'b0;
    logic [31:0] seed = '0;
    logic [1:0]  slot = '0;
    logic [W-1:0] out;
    logic        busy, restore_err;

    int n_vec = 0, n_err = 0;

    logic [W-1:0] mw [$];
    logic [W-1:0] ms [NSL][L];
    bit           mv [NSL];
    bit           exp_err;
    logic [W-1:0] rec [5];
    logic [W-1:0] rec2 [8];

    rnd_vec_gen_mslot #(
        .OUT_SIZE(W), .LFSR_LENGTH(L), .LFSR_FEEDBACK(F), .SLOTS(NSL), .WARMUP(WU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed_start(seed_start), .seed(seed),
        .save(save), .restore(restore), .next(next), .slot(slot),
        .out(out), .busy(busy), .restore_err(restore_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        mw = {};
        mw.push_back(W'(1));
        for (int i = 1; i < L; i++) mw.push_back('0);
        for (int k = 0; k < NSL; k++) mv[k] = 0;
        exp_err = 0;
    endtask

    task automatic m_step();
        logic [W-1:0] sum;
        bit any;
        sum = mw[L-1] + mw[F-1];
        any = 0;
        foreach (mw[i]) if (mw[i][0]) any = 1;
        if (!any) sum[0] = 1'b1;
        void'(mw.pop_back());
        mw.push_front(sum);
    endtask

    task automatic m_seed(input logic [31:0] sd);
        logic [31:0] x;
        x = (sd == 0) ? 32'h1 : sd;
        for (int i = 0; i < L; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
            void'(mw.pop_back());
            mw.push_front(x[W-1:0]);
        end
        for (int i = 0; i < WU; i++) m_step();
    endtask

    task automatic m_cmd(input bit nx, input bit sv, input bit rs, input int sl);
        exp_err = 0;
        if (rs) begin
            if (mv[sl]) for (int i = 0; i < L; i++) mw[i] = ms[sl][i];
            else exp_err = 1;
        end else if (sv) begin
            for (int i = 0; i < L; i++) ms[sl][i] = mw[i];
            mv[sl] = 1;
        end else if (nx) m_step();
    endtask

    task automatic tick(input bit nx, input bit sv, input bit rs, input bit ss,
                        input logic [1:0] sl, input logic [31:0] sd);
        next = nx; save = sv; restore = rs; seed_start = ss; slot = sl; seed = sd;
        @(posedge clk);
        #1;
        next = 0; save = 0; restore = 0; seed_start = 0;
    endtask

    task automatic op(input string tag, input bit nx, input bit sv, input bit rs, input logic [1:0] sl);
        tick(nx, sv, rs, 1'b0, sl, '0);
        m_cmd(nx, sv, rs, int'(sl));
        chk({tag, "_out"}, out, mw[0]);
        chk({tag, "_err"}, restore_err, exp_err);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic seed_run(input logic [31:0] sd);
        int n;
        n = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, sd);
        while (busy && n < 100) begin
            n++;
            tick(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
        end
        chk("busy_len", n, L + WU);
        m_seed(sd);
        exp_err = 0;
        chk("seed_out", out, mw[0]);
        chk("seed_err", restore_err, 0);
    endtask

    initial begin
        int run, max_run;
        m_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out", out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", restore_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) op("first3", 1, 0, 0, 0);
        chk("seq_third", out, 1);

        for (int i = 0; i < 10; i++) op("run10", 1, 0, 0, 0);
        op("save2", 0, 1, 0, 2);
        for (int i = 0; i < 5; i++) begin
            op("run5", 1, 0, 0, 0);
            rec[i] = out;
        end
        op("restore2", 0, 0, 1, 2);
        for (int i = 0; i < 5; i++) begin
            op("replay", 1, 0, 0, 0);
            chk("replay_eq", out, rec[i]);
        end

        op("bad_restore", 0, 0, 1, 1);
        chk("bad_restore_pulse", restore_err, 1);
        op("save_next", 1, 1, 0, 3);
        chk("err_cleared", restore_err, 0);

        seed_run(32'h0);
        for (int i = 0; i < 8; i++) begin
            op("seed0", 1, 0, 0, 0);
            rec2[i] = out;
        end
        seed_run(32'h1);
        for (int i = 0; i < 8; i++) begin
            op("seed1", 1, 0, 0, 0);
            chk("seed_same", out, rec2[i]);
        end

        tick(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h1234_5678);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_out", out, 1);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op("post_rst_restore", 0, 0, 1, 2);
        chk("post_rst_pulse", restore_err, 1);

        seed_run(32'hDEAD_BEEF);
        run = 0;
        max_run = 0;
        for (int i = 0; i < 1000; i++) begin
            op("long", 1, 0, 0, 0);
            run = out[0] ? 0 : run + 1;
            if (run > max_run) max_run = run;
        end
        chk("even_run_bounded", max_run <= L, 1);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 15);
            op("mix", r < 10 || r == 15, r == 10 || r == 11 || r == 15, r == 12 || r == 13,
               2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
